// File: rtl/gpio_reg_pkg.sv
// GPIO register-file interface types and edge-polarity constants.
// Shared by gpio_ctrl and gpio_debounce.
package gpio_reg_pkg;

  localparam logic GPIO_EDGE_RISING  = 1'b1;
  localparam logic GPIO_EDGE_FALLING = 1'b0;

  typedef struct packed {
    logic dir;
    logic en;
    logic out;
    logic toggle;
    logic intrpt_en;
    logic intrpt;
    logic intrpt_edge;
  } gpio_reg2hw_t;

  typedef struct packed {
    logic sync_in;
    logic out;
    logic out_valid;
    logic intrpt;
    logic intrpt_valid;
  } gpio_hw2reg_t;

  typedef enum logic {
    DB_STABLE,
    DB_PENDING
  } db_state_e;

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin debounce filter: filt_o follows sync_i after DebounceCycles stable cycles.
// Ports: clk_i, rst_i (sync, active-high), sync_i (synchronised pad), filt_o (filtered).
module gpio_debounce
  import gpio_reg_pkg::*;
#(
  parameter int DebounceCycles = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sync_i,
  output logic filt_o
);

  localparam int CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  db_state_e       state;
  logic [CntW-1:0] cnt;

  // The count never passes CntLast: reaching it always resolves the pin.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= DB_STABLE;
      cnt    <= '0;
      filt_o <= 1'b0;
    end else begin
      unique case (state)
        DB_STABLE: begin
          if (sync_i != filt_o) begin
            if (cnt == CntLast) begin
              filt_o <= sync_i;
            end else begin
              state <= DB_PENDING;
              cnt   <= cnt + 1'b1;
            end
          end
        end
        DB_PENDING: begin
          if (sync_i == filt_o) begin
            state <= DB_STABLE;
            cnt   <= '0;
          end else if (cnt == CntLast) begin
            filt_o <= sync_i;
            state  <= DB_STABLE;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/gpio_ctrl.sv
// Per-pin GPIO control: input sync, optional debounce (GPIO_DEBOUNCE_EN), edge irq, toggle, pads.
// Ports: clk_i, rst_i, reg2hw_i, hw2reg_o, gpio_in_i, gpio_out_o, gpio_oe_o, irq_o.
module gpio_ctrl
  import gpio_reg_pkg::*;
#(
  parameter int GpioCount      = 16,
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  gpio_reg2hw_t [GpioCount-1:0]   reg2hw_i,
  output gpio_hw2reg_t [GpioCount-1:0]   hw2reg_o,
  input  logic         [GpioCount-1:0]   gpio_in_i,
  output logic         [GpioCount-1:0]   gpio_out_o,
  output logic         [GpioCount-1:0]   gpio_oe_o,
  output logic                           irq_o
);

  if (SyncStages < 2) begin : g_chk_sync
    $error("SyncStages must be at least 2");
  end
  if (DebounceCycles < 1) begin : g_chk_db
    $error("DebounceCycles must be at least 1");
  end

  logic [SyncStages-1:0][GpioCount-1:0] sync_q;
  logic [GpioCount-1:0] sync;
  logic [GpioCount-1:0] filt;
  logic [GpioCount-1:0] prev_q;
  logic [GpioCount-1:0] rise;
  logic [GpioCount-1:0] fall;
  logic [GpioCount-1:0] edge_hit;
  logic [GpioCount-1:0] irq_src;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= gpio_in_i;
      for (int s = 1; s < SyncStages; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SyncStages-1];

`ifdef GPIO_DEBOUNCE_EN
  for (genvar i = 0; i < GpioCount; i++) begin : g_db
    gpio_debounce #(
      .DebounceCycles(DebounceCycles)
    ) u_db (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .sync_i(sync[i]),
      .filt_o(filt[i])
    );
  end
`else
  assign filt = sync;
`endif

  // prev tracks filt even while a pin is disabled, so enabling it
  // later never reports a stale edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= '0;
      irq_o  <= 1'b0;
    end else begin
      prev_q <= filt;
      irq_o  <= |irq_src;
    end
  end

  assign rise = filt & ~prev_q;
  assign fall = ~filt & prev_q;

  always_comb begin
    edge_hit   = '0;
    irq_src    = '0;
    gpio_oe_o  = '0;
    gpio_out_o = '0;
    hw2reg_o   = '0;
    for (int i = 0; i < GpioCount; i++) begin
      unique case (reg2hw_i[i].intrpt_edge)
        GPIO_EDGE_RISING:  edge_hit[i] = rise[i];
        GPIO_EDGE_FALLING: edge_hit[i] = fall[i];
      endcase
      irq_src[i] = reg2hw_i[i].intrpt & reg2hw_i[i].intrpt_en;
      gpio_oe_o[i]  = reg2hw_i[i].en & reg2hw_i[i].dir;
      gpio_out_o[i] = reg2hw_i[i].out & gpio_oe_o[i];
      hw2reg_o[i].sync_in   = filt[i];
      hw2reg_o[i].out_valid = reg2hw_i[i].toggle;
      hw2reg_o[i].out       = reg2hw_i[i].out ^ reg2hw_i[i].toggle;
      hw2reg_o[i].intrpt_valid = edge_hit[i] & reg2hw_i[i].en
                               & reg2hw_i[i].intrpt_en;
      hw2reg_o[i].intrpt = hw2reg_o[i].intrpt_valid;
    end
  end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl with a queue-based reference model.
// Define GPIO_DEBOUNCE_EN to exercise the debounce filter.
module tb_gpio_ctrl;
  import gpio_reg_pkg::*;

  localparam int N = 16;
  localparam int S = 2;
  localparam int D = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = S + D;
`else
  localparam int LAT = S;
`endif

  logic clk = 1'b0;
  logic rst;
  gpio_reg2hw_t [N-1:0] r;
  gpio_hw2reg_t [N-1:0] hw;
  logic [N-1:0] pad, gout, goe;
  logic irq;

  always #5 clk = ~clk;

  gpio_ctrl #(
    .GpioCount(N), .SyncStages(S), .DebounceCycles(D)
  ) dut (
    .clk_i(clk), .rst_i(rst), .reg2hw_i(r), .hw2reg_o(hw),
    .gpio_in_i(pad), .gpio_out_o(gout), .gpio_oe_o(goe), .irq_o(irq)
  );

  int nvec = 0;
  int nerr = 0;

  logic [N-1:0] a_sync, a_out, a_ov, a_int, a_iv;
  always_comb begin
    a_sync = '0; a_out = '0; a_ov = '0; a_int = '0; a_iv = '0;
    for (int i = 0; i < N; i++) begin
      a_sync[i] = hw[i].sync_in;
      a_out[i]  = hw[i].out;
      a_ov[i]   = hw[i].out_valid;
      a_int[i]  = hw[i].intrpt;
      a_iv[i]   = hw[i].intrpt_valid;
    end
  end

  // Reference model: pad history delay line, filtered value, previous
  // filtered value, run lengths of disagreement, registered irq.
  logic [N-1:0] hist[$];
  logic [N-1:0] mfilt = '0;
  logic [N-1:0] mprev = '0;
  logic         mirq  = 1'b0;
  int           run[N];

  logic [N-1:0] e_sync, e_out, e_ov, e_iv, e_oe, e_gout;
  logic         e_irq;

  function automatic void model_edge();
    logic [N-1:0] old_sync;
    logic any;
    if (rst) begin
      hist.delete();
      for (int k = 0; k < S; k++) hist.push_back('0);
      mfilt = '0; mprev = '0; mirq = 1'b0;
      for (int i = 0; i < N; i++) run[i] = 0;
    end else begin
      old_sync = hist[0];
      any = 1'b0;
      for (int i = 0; i < N; i++)
        if (r[i].intrpt && r[i].intrpt_en) any = 1'b1;
      mirq = any;
      mprev = mfilt;
      hist.push_back(pad);
      void'(hist.pop_front());
`ifdef GPIO_DEBOUNCE_EN
      for (int i = 0; i < N; i++) begin
        if (old_sync[i] != mfilt[i]) begin
          run[i]++;
          if (run[i] == D) begin
            mfilt[i] = old_sync[i];
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
`else
      mfilt = hist[0];
`endif
    end
  endfunction

  function automatic void model_comb();
    logic e;
    e_sync = mfilt;
    e_irq = mirq;
    for (int i = 0; i < N; i++) begin
      if (r[i].intrpt_edge) e = mfilt[i] & ~mprev[i];
      else                  e = ~mfilt[i] & mprev[i];
      e_iv[i]   = e & r[i].en & r[i].intrpt_en;
      e_ov[i]   = r[i].toggle;
      e_out[i]  = r[i].out ^ r[i].toggle;
      e_oe[i]   = r[i].en & r[i].dir;
      e_gout[i] = r[i].out & e_oe[i];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
    model_comb();
  endtask

  task automatic do_reset();
    rst = 1'b1; r = '0; pad = '0;
    tick();
    rst = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    rst = 1'b1; r = '0; pad = N'($urandom);
    tick(); tick();
    pad = '0; rst = 1'b0;
    settle();
    nvec++; if (a_sync !== 16'h0) begin nerr++;
      $display("FAIL reset_sync: got %h want 0000", a_sync); end
    nvec++; if (a_ov !== 16'h0) begin nerr++;
      $display("FAIL reset_out_valid: got %h want 0000", a_ov); end
    nvec++; if (a_iv !== 16'h0) begin nerr++;
      $display("FAIL reset_intrpt_valid: got %h want 0000", a_iv); end
    nvec++; if (irq !== 1'b0) begin nerr++;
      $display("FAIL reset_irq: got %b want 0", irq); end
    nvec++; if (goe !== 16'h0 || gout !== 16'h0) begin nerr++;
      $display("FAIL reset_pads: got oe=%h out=%h want 0", goe, gout); end
  endtask

  task automatic test_sync();
    do_reset();
    pad = 16'h0001;
    settle();
    for (int k = 1; k <= LAT; k++) begin
      tick(); settle();
      nvec++; if (a_sync[0] !== (k == LAT)) begin nerr++;
        $display("FAIL sync_latency k=%0d: got %b want %b",
                 k, a_sync[0], (k == LAT)); end
      nvec++; if (a_sync !== e_sync) begin nerr++;
        $display("FAIL sync_model k=%0d: got %h want %h", k, a_sync, e_sync); end
      nvec++; if (a_iv !== 16'h0 || irq !== 1'b0 || goe !== 16'h0) begin
        nerr++; $display("FAIL sync_quiet: got iv=%h irq=%b oe=%h want 0",
                         a_iv, irq, goe); end
    end
  endtask

  task automatic test_irq_rise();
    int pulses;
    do_reset();
    r[3].en = 1'b1; r[3].intrpt_en = 1'b1;
    r[3].intrpt_edge = GPIO_EDGE_RISING;
    pad[3] = 1'b1;
    pulses = 0;
    repeat (LAT + 4) begin
      tick(); settle();
      nvec++; if (a_iv !== e_iv || a_int !== e_iv) begin nerr++;
        $display("FAIL irq_rise_model: got iv=%h int=%h want %h",
                 a_iv, a_int, e_iv); end
      pulses += int'(a_iv[3]);
    end
    nvec++; if (pulses != 1) begin nerr++;
      $display("FAIL irq_rise_pulses: got %0d want 1", pulses); end
    r[3].intrpt = 1'b1;
    settle();
    tick(); settle();
    nvec++; if (irq !== 1'b1) begin nerr++;
      $display("FAIL irq_aggregate: got %b want 1", irq); end
    r[3].intrpt = 1'b0;
    tick(); settle();
    nvec++; if (irq !== 1'b0) begin nerr++;
      $display("FAIL irq_clear: got %b want 0", irq); end
    pad[3] = 1'b0;
    pulses = 0;
    repeat (LAT + 4) begin
      tick(); settle();
      pulses += int'(a_iv[3]);
    end
    nvec++; if (pulses != 0) begin nerr++;
      $display("FAIL irq_fall_ignored: got %0d want 0", pulses); end
  endtask

  task automatic test_toggle();
    do_reset();
    r[5].en = 1'b1; r[5].dir = 1'b1; r[5].out = 1'b1;
    settle();
    nvec++; if (goe[5] !== 1'b1 || gout[5] !== 1'b1) begin nerr++;
      $display("FAIL toggle_drive: got oe=%b out=%b want 1 1",
               goe[5], gout[5]); end
    r[5].toggle = 1'b1;
    settle();
    nvec++; if (a_ov[5] !== 1'b1 || a_out[5] !== 1'b0) begin nerr++;
      $display("FAIL toggle_pulse: got valid=%b out=%b want 1 0",
               a_ov[5], a_out[5]); end
    nvec++; if (goe[5] !== 1'b1) begin nerr++;
      $display("FAIL toggle_oe: got %b want 1", goe[5]); end
    tick();
    r[5].toggle = 1'b0;
    settle();
    nvec++; if (a_ov[5] !== 1'b0 || a_out[5] !== 1'b1) begin nerr++;
      $display("FAIL toggle_idle: got valid=%b out=%b want 0 1",
               a_ov[5], a_out[5]); end
    r[5].dir = 1'b0;
    settle();
    nvec++; if (goe[5] !== 1'b0 || gout[5] !== 1'b0) begin nerr++;
      $display("FAIL toggle_input_dir: got oe=%b out=%b want 0 0",
               goe[5], gout[5]); end
  endtask

  task automatic test_disabled();
    int pulses;
    do_reset();
    r[2].en = 1'b0; r[2].intrpt_en = 1'b1;
    r[2].intrpt_edge = GPIO_EDGE_RISING;
    pad[2] = 1'b1;
    pulses = 0;
    repeat (LAT + 4) begin
      tick(); settle();
      pulses += int'(a_iv[2]);
    end
    r[2].en = 1'b1;
    repeat (4) begin
      settle();
      pulses += int'(a_iv[2]);
      tick();
    end
    settle();
    nvec++; if (pulses != 0) begin nerr++;
      $display("FAIL disabled_no_irq: got %0d want 0", pulses); end
    nvec++; if (a_sync[2] !== 1'b1) begin nerr++;
      $display("FAIL disabled_sync: got %b want 1", a_sync[2]); end
  endtask

`ifdef GPIO_DEBOUNCE_EN
  task automatic test_debounce();
    do_reset();
    pad[0] = 1'b1;
    repeat (3) tick();
    pad[0] = 1'b0;
    repeat (LAT + 4) begin
      tick(); settle();
      nvec++; if (a_sync[0] !== 1'b0) begin nerr++;
        $display("FAIL debounce_glitch: got %b want 0", a_sync[0]); end
    end
    pad[0] = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k == 5) pad[0] = 1'b0;
      settle();
      nvec++; if (a_sync[0] !== (k == LAT)) begin nerr++;
        $display("FAIL debounce_accept k=%0d: got %b want %b",
                 k, a_sync[0], (k == LAT)); end
    end
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    r[1].intrpt = 1'b1; r[1].intrpt_en = 1'b1;
    pad = 16'h0001;
    repeat (3) tick();
    settle();
    nvec++; if (irq !== 1'b1) begin nerr++;
      $display("FAIL midrst_irq_before: got %b want 1", irq); end
    rst = 1'b1; r = '0;
    tick();
    rst = 1'b0;
    settle();
    nvec++; if (irq !== 1'b0 || a_sync !== 16'h0) begin nerr++;
      $display("FAIL midrst_cleared: got irq=%b sync=%h want 0 0000",
               irq, a_sync); end
    for (int k = 1; k <= LAT; k++) begin
      tick(); settle();
      nvec++; if (a_sync[0] !== (k == LAT)) begin nerr++;
        $display("FAIL midrst_relatch k=%0d: got %b want %b",
                 k, a_sync[0], (k == LAT)); end
    end
  endtask

  task automatic test_random();
    logic [6:0] cfg;
    do_reset();
    repeat (400) begin
      for (int i = 0; i < N; i++) begin
        cfg = 7'($urandom);
        r[i] = cfg;
      end
      pad = pad ^ (N'($urandom) & N'($urandom) & N'($urandom));
      rst = ($urandom_range(0, 63) == 0);
      settle();
      nvec++; if (a_sync !== e_sync) begin nerr++;
        $display("FAIL rnd_sync: got %h want %h", a_sync, e_sync); end
      nvec++; if (a_iv !== e_iv || a_int !== e_iv) begin nerr++;
        $display("FAIL rnd_intrpt: got iv=%h int=%h want %h",
                 a_iv, a_int, e_iv); end
      nvec++; if (a_ov !== e_ov || a_out !== e_out) begin nerr++;
        $display("FAIL rnd_toggle: got v=%h o=%h want v=%h o=%h",
                 a_ov, a_out, e_ov, e_out); end
      nvec++; if (goe !== e_oe || gout !== e_gout) begin nerr++;
        $display("FAIL rnd_pads: got oe=%h out=%h want oe=%h out=%h",
                 goe, gout, e_oe, e_gout); end
      nvec++; if (irq !== e_irq) begin nerr++;
        $display("FAIL rnd_irq: got %b want %b", irq, e_irq); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; r = '0; pad = '0;
    test_reset();
    test_sync();
    test_irq_rise();
    test_toggle();
    test_disabled();
`ifdef GPIO_DEBOUNCE_EN
    test_debounce();
`endif
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
